// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing: default 640x480@60 constants, coordinate width,
// period/sync-window helpers and the registered output bundle.
package vga_timing_pkg;

    localparam int COORD_W   = 11;
    localparam int COORD_MAX = 2047;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_PULSE  = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_PIXELS = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_PULSE  = 2;
    localparam int DEF_V_BP     = 33;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   h_sync;
        logic   v_sync;
        logic   disp_ena;
        logic   frame_start;
        coord_t column;
        coord_t row;
    } raster_out_t;

    function automatic int axis_period(int pixels, int fp, int pulse, int bp);
        return pixels + fp + pulse + bp;
    endfunction

    function automatic int sync_first(int pixels, int fp);
        return pixels + fp;
    endfunction

    // Exclusive upper bound of the sync window.
    function automatic int sync_end(int pixels, int fp, int pulse);
        return pixels + fp + pulse;
    endfunction

    function automatic raster_out_t idle_outputs(logic h_pol, logic v_pol);
        raster_out_t o;
        o        = '0;
        o.h_sync = ~h_pol;
        o.v_sync = ~v_pol;
        return o;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, terminal count,
// active-window and sync-window decode of the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int period     = 800,
    parameter int active_len = 640,
    parameter int sync_lo    = 656,
    parameter int sync_hi    = 752
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   enable,
    output coord_t count,
    output logic   terminal,
    output logic   active,
    output logic   in_sync
);

    localparam coord_t LAST       = coord_t'(period - 1);
    localparam coord_t ACTIVE_END = coord_t'(active_len);
    localparam coord_t SYNC_LO    = coord_t'(sync_lo);
    localparam coord_t SYNC_HI    = coord_t'(sync_hi);

    assign terminal = (count == LAST);
    assign active   = (count < ACTIVE_END);
    assign in_sync  = (count >= SYNC_LO) && (count < SYNC_HI);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + coord_t'(1);
        end
    end

endmodule

// File: rtl/vga_sync_controller.sv
// VGA raster timing generator: free-running h/v counters decoded into
// registered sync, display-enable, coordinates and a frame-start pulse.
module vga_sync_controller
    import vga_timing_pkg::*;
#(
    parameter int   h_pixels = DEF_H_PIXELS,
    parameter int   h_fp     = DEF_H_FP,
    parameter int   h_pulse  = DEF_H_PULSE,
    parameter int   h_bp     = DEF_H_BP,
    parameter logic h_pol    = 1'b0,
    parameter int   v_pixels = DEF_V_PIXELS,
    parameter int   v_fp     = DEF_V_FP,
    parameter int   v_pulse  = DEF_V_PULSE,
    parameter int   v_bp     = DEF_V_BP,
    parameter logic v_pol    = 1'b0
) (
    input  logic               pixel_clk,
    input  logic               reset_n,
    output logic               h_sync,
    output logic               v_sync,
    output logic               disp_ena,
    output logic [COORD_W-1:0] column,
    output logic [COORD_W-1:0] row,
    output logic               frame_start
);

    localparam int H_PERIOD = axis_period(h_pixels, h_fp, h_pulse, h_bp);
    localparam int V_PERIOD = axis_period(v_pixels, v_fp, v_pulse, v_bp);

    if (H_PERIOD > COORD_MAX || V_PERIOD > COORD_MAX) begin : g_period_check
        $error("vga_sync_controller: raster period exceeds 11-bit counter range");
    end

    coord_t      h_count, v_count;
    logic        h_last, v_last;
    logic        h_active, v_active;
    logic        h_in_sync, v_in_sync;
    logic        at_origin;
    raster_out_t out_q, out_nxt;

    vga_axis_counter #(
        .period    (H_PERIOD),
        .active_len(h_pixels),
        .sync_lo   (sync_first(h_pixels, h_fp)),
        .sync_hi   (sync_end(h_pixels, h_fp, h_pulse))
    ) u_h_axis (
        .clk     (pixel_clk),
        .reset_n (reset_n),
        .enable  (1'b1),
        .count   (h_count),
        .terminal(h_last),
        .active  (h_active),
        .in_sync (h_in_sync)
    );

    vga_axis_counter #(
        .period    (V_PERIOD),
        .active_len(v_pixels),
        .sync_lo   (sync_first(v_pixels, v_fp)),
        .sync_hi   (sync_end(v_pixels, v_fp, v_pulse))
    ) u_v_axis (
        .clk     (pixel_clk),
        .reset_n (reset_n),
        .enable  (h_last),
        .count   (v_count),
        .terminal(v_last),
        .active  (v_active),
        .in_sync (v_in_sync)
    );

    always_comb begin
        out_nxt             = out_q;
        out_nxt.h_sync      = h_in_sync ? h_pol : ~h_pol;
        out_nxt.v_sync      = v_in_sync ? v_pol : ~v_pol;
        out_nxt.disp_ena    = h_active & v_active;
        out_nxt.frame_start = at_origin;
        if (h_active) out_nxt.column = h_count;
        if (v_active) out_nxt.row = v_count;
    end

    // at_origin tracks "counters sit at (0,0)": true after reset and
    // whenever both axes wrap together on the previous edge.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            out_q     <= idle_outputs(h_pol, v_pol);
            at_origin <= 1'b1;
        end else begin
            out_q     <= out_nxt;
            at_origin <= h_last & v_last;
        end
    end

    assign h_sync      = out_q.h_sync;
    assign v_sync      = out_q.v_sync;
    assign disp_ena    = out_q.disp_ena;
    assign frame_start = out_q.frame_start;
    assign column      = out_q.column;
    assign row         = out_q.row;

endmodule
